// File: rtl/result_drain_buffer.sv
// Result drain buffer: captures ARRAY_SIZE-lane result beats from the array bottom,
// removes the WS diagonal skew and streams the N x M matrix out row-major.
module result_drain_buffer #(
    parameter int unsigned ACC_WIDTH      = 32,
    parameter int unsigned ARRAY_SIZE     = 8,
    parameter int unsigned INDEX_WIDTH    = 8,
    parameter int unsigned MODE_SIG_WIDTH = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [INDEX_WIDTH-1:0]          N,
    input  logic [INDEX_WIDTH-1:0]          M,
    input  logic [MODE_SIG_WIDTH-1:0]       buffer_mode,
    input  logic                            in_valid,
    input  logic [ARRAY_SIZE*ACC_WIDTH-1:0] data_in,
    output logic [ACC_WIDTH-1:0]            data_out,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            capture_done,
    output logic                            drain_done,
    output logic                            busy,
    output logic                            cmd_err
);

    localparam int unsigned TW = INDEX_WIDTH + 1;
    localparam int unsigned RW = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CAPTURE = 2'd1;
    localparam logic [1:0] S_FULL    = 2'd2;
    localparam logic [1:0] S_DRAIN   = 2'd3;

    localparam logic [MODE_SIG_WIDTH-1:0] MODE_ABORT = MODE_SIG_WIDTH'(0);
    localparam logic [MODE_SIG_WIDTH-1:0] MODE_WS    = MODE_SIG_WIDTH'(1);
    localparam logic [MODE_SIG_WIDTH-1:0] MODE_OS    = MODE_SIG_WIDTH'(2);
    localparam logic [MODE_SIG_WIDTH-1:0] MODE_DRAIN = MODE_SIG_WIDTH'(3);

    logic [1:0]             r_state, w_state;
    logic [INDEX_WIDTH-1:0] r_n, w_n, r_m, w_m;
    logic                   r_os, w_os;
    logic [TW-1:0]          r_t, w_t;
    logic [INDEX_WIDTH-1:0] r_row, w_row, r_col, w_col;
    logic [ACC_WIDTH-1:0]   r_data_out, w_data_out;
    logic                   r_out_valid, w_out_valid;
    logic                   r_capture_done, w_capture_done;
    logic                   r_drain_done, w_drain_done;
    logic                   r_busy, w_busy;
    logic                   r_cmd_err, w_cmd_err;

    logic [ACC_WIDTH-1:0]   r_res [ARRAY_SIZE][ARRAY_SIZE];

    logic                   w_start, w_range_ok, w_last_beat, w_capture_beat;
    logic                   w_col_wrap, w_drain_last;
    logic [INDEX_WIDTH-1:0] w_row_adv, w_col_adv;
    logic [ACC_WIDTH-1:0]   w_fetch;
    logic [ARRAY_SIZE-1:0]  w_wr_en;
    logic [RW-1:0]          w_wr_row [ARRAY_SIZE];

    assign w_start    = (buffer_mode == MODE_WS) || (buffer_mode == MODE_OS);
    assign w_range_ok = (N != '0) && (N <= INDEX_WIDTH'(ARRAY_SIZE)) &&
                        (M != '0) && (M <= INDEX_WIDTH'(ARRAY_SIZE));
    // WS results trail by the skew, so the last beat is N+M-2 rather than N-1
    assign w_last_beat = r_os ? (r_t == TW'(r_n) - TW'(1))
                              : (r_t == TW'(r_n) + TW'(r_m) - TW'(2));
    assign w_capture_beat = (r_state == S_CAPTURE) && in_valid && (buffer_mode != MODE_ABORT);

    assign w_col_wrap   = (r_col == r_m - INDEX_WIDTH'(1));
    assign w_drain_last = w_col_wrap && (r_row == r_n - INDEX_WIDTH'(1));
    assign w_row_adv    = w_col_wrap ? r_row + INDEX_WIDTH'(1) : r_row;
    assign w_col_adv    = w_col_wrap ? '0 : r_col + INDEX_WIDTH'(1);
    assign w_fetch      = r_res[RW'(w_row_adv)][RW'(w_col_adv)];

    // Per-lane write enable and destination row for the current beat
    always_comb begin
        w_wr_en = '0;
        for (int c = 0; c < ARRAY_SIZE; c++) begin
            w_wr_row[c] = '0;
            if (TW'(c) < TW'(r_m)) begin
                if (r_os) begin
                    w_wr_en[c]  = 1'b1;
                    w_wr_row[c] = RW'(r_t);
                end else if ((r_t >= TW'(c)) && ((r_t - TW'(c)) < TW'(r_n))) begin
                    w_wr_en[c]  = 1'b1;
                    w_wr_row[c] = RW'(r_t - TW'(c));
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < ARRAY_SIZE; r++)
                for (int c = 0; c < ARRAY_SIZE; c++)
                    r_res[r][c] <= '0;
        end else if (w_capture_beat) begin
            for (int c = 0; c < ARRAY_SIZE; c++)
                if (w_wr_en[c])
                    r_res[w_wr_row[c]][c] <= data_in[c*ACC_WIDTH +: ACC_WIDTH];
        end
    end

    always_comb begin
        w_state        = r_state;
        w_n            = r_n;
        w_m            = r_m;
        w_os           = r_os;
        w_t            = r_t;
        w_row          = r_row;
        w_col          = r_col;
        w_data_out     = r_data_out;
        w_out_valid    = r_out_valid;
        w_capture_done = 1'b0;
        w_drain_done   = 1'b0;
        w_cmd_err      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    if (w_range_ok) begin
                        w_state = S_CAPTURE;
                        w_n     = N;
                        w_m     = M;
                        w_os    = (buffer_mode == MODE_OS);
                        w_t     = '0;
                    end else begin
                        w_cmd_err = 1'b1;
                    end
                end
            end
            S_CAPTURE: begin
                if (buffer_mode == MODE_ABORT) begin
                    w_state = S_IDLE;
                end else if (in_valid) begin
                    if (w_last_beat) begin
                        w_state        = S_FULL;
                        w_capture_done = 1'b1;
                    end else begin
                        w_t = r_t + TW'(1);
                    end
                end
            end
            S_FULL: begin
                if (buffer_mode == MODE_DRAIN) begin
                    w_state     = S_DRAIN;
                    w_row       = '0;
                    w_col       = '0;
                    w_out_valid = 1'b1;
                    w_data_out  = r_res[0][0];
                end else if (w_start) begin
                    w_cmd_err = 1'b1;
                end
            end
            default: begin
                if (buffer_mode == MODE_ABORT) begin
                    w_state     = S_IDLE;
                    w_out_valid = 1'b0;
                    w_data_out  = '0;
                end else if (r_out_valid && out_ready) begin
                    if (w_drain_last) begin
                        w_state      = S_IDLE;
                        w_out_valid  = 1'b0;
                        w_data_out   = '0;
                        w_drain_done = 1'b1;
                    end else begin
                        w_row      = w_row_adv;
                        w_col      = w_col_adv;
                        w_data_out = w_fetch;
                    end
                end
            end
        endcase
        w_busy = (w_state == S_CAPTURE) || (w_state == S_DRAIN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= S_IDLE;
            r_n            <= '0;
            r_m            <= '0;
            r_os           <= 1'b0;
            r_t            <= '0;
            r_row          <= '0;
            r_col          <= '0;
            r_data_out     <= '0;
            r_out_valid    <= 1'b0;
            r_capture_done <= 1'b0;
            r_drain_done   <= 1'b0;
            r_busy         <= 1'b0;
            r_cmd_err      <= 1'b0;
        end else begin
            r_state        <= w_state;
            r_n            <= w_n;
            r_m            <= w_m;
            r_os           <= w_os;
            r_t            <= w_t;
            r_row          <= w_row;
            r_col          <= w_col;
            r_data_out     <= w_data_out;
            r_out_valid    <= w_out_valid;
            r_capture_done <= w_capture_done;
            r_drain_done   <= w_drain_done;
            r_busy         <= w_busy;
            r_cmd_err      <= w_cmd_err;
        end
    end

    assign data_out     = r_data_out;
    assign out_valid    = r_out_valid;
    assign capture_done = r_capture_done;
    assign drain_done   = r_drain_done;
    assign busy         = r_busy;
    assign cmd_err      = r_cmd_err;

endmodule

// File: tb/tb_result_drain_buffer.sv
// Directed bench for result_drain_buffer: WS/OS capture, drain ordering, backpressure,
// command rejection, abort and reset.
module tb_result_drain_buffer;

    localparam int unsigned AW = 32;
    localparam int unsigned AS = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    N, M;
    logic [1:0]    buffer_mode;
    logic          in_valid;
    logic [AS*AW-1:0] data_in;
    logic [AW-1:0] data_out;
    logic          out_valid, out_ready, capture_done, drain_done, busy, cmd_err;

    int n_vec = 0;
    int n_err = 0;

    result_drain_buffer #(
        .ACC_WIDTH(AW), .ARRAY_SIZE(AS), .INDEX_WIDTH(8), .MODE_SIG_WIDTH(2)
    ) dut (
        .clk(clk), .reset(reset), .N(N), .M(M), .buffer_mode(buffer_mode),
        .in_valid(in_valid), .data_in(data_in), .data_out(data_out),
        .out_valid(out_valid), .out_ready(out_ready), .capture_done(capture_done),
        .drain_done(drain_done), .busy(busy), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // OS beat: lane c = base + 8t + c
    function automatic logic [AS*AW-1:0] os_beat(input logic [31:0] base, input int t);
        logic [AS*AW-1:0] v;
        for (int c = 0; c < AS; c++) v[c*AW +: AW] = base + 32'(8*t + c);
        return v;
    endfunction

    // WS beat for N=3,M=2: lane c = 16*(t-c)+c where valid, marker garbage elsewhere
    function automatic logic [AS*AW-1:0] ws_beat(input int t);
        logic [AS*AW-1:0] v;
        for (int c = 0; c < AS; c++) begin
            if (c < 2 && t >= c && (t - c) < 3) v[c*AW +: AW] = 32'(16*(t-c) + c);
            else                                v[c*AW +: AW] = 32'hDEAD_0000 + 32'(c);
        end
        return v;
    endfunction

    // OS capture with mode 11 held afterwards so FULL moves straight into DRAIN
    task automatic os_capture(input int n, input int m, input bit gap, input logic [31:0] base);
        @(negedge clk);
        buffer_mode = 2'b10; N = 8'(n); M = 8'(m); in_valid = 1'b0;
        for (int t = 0; t < n; t++) begin
            if (gap) begin
                @(negedge clk);
                buffer_mode = 2'b11; in_valid = 1'b0; data_in = '1;
            end
            @(negedge clk);
            buffer_mode = 2'b11; in_valid = 1'b1; data_in = os_beat(base, t);
        end
        @(negedge clk);
        in_valid = 1'b0; data_in = '1;
        chk("os_capture_done", capture_done, 1);
        chk("os_busy_full", busy, 0);
    endtask

    initial begin
        logic [31:0] ws_exp [6];
        ws_exp = '{32'h00, 32'h01, 32'h10, 32'h11, 32'h20, 32'h21};
        reset = 1'b0; N = '0; M = '0; buffer_mode = 2'b00; in_valid = 1'b0;
        data_in = '0; out_ready = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_capture_done", capture_done, 0);
        chk("rst_drain_done", drain_done, 0);
        chk("rst_cmd_err", cmd_err, 0);
        @(negedge clk);
        reset = 1'b1;

        // WS N=3, M=2 with deskew
        @(negedge clk);
        buffer_mode = 2'b01; N = 8'd3; M = 8'd2; out_ready = 1'b1;
        @(negedge clk);
        chk("ws_busy_capture", busy, 1);
        buffer_mode = 2'b11; in_valid = 1'b1; data_in = ws_beat(0);
        for (int t = 1; t < 4; t++) begin
            @(negedge clk);
            chk("ws_no_early_done", capture_done, 0);
            data_in = ws_beat(t);
        end
        @(negedge clk);
        in_valid = 1'b0; data_in = '1;
        chk("ws_capture_done", capture_done, 1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("ws_out_valid", out_valid, 1);
            chk("ws_data", data_out, ws_exp[k]);
        end
        @(negedge clk);
        chk("ws_drain_done", drain_done, 1);
        chk("ws_valid_low", out_valid, 0);
        chk("ws_data_zero", data_out, 0);
        buffer_mode = 2'b00;

        // OS N=M=8 with in_valid toggling
        os_capture(8, 8, 1'b1, 32'h0);
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            chk("os_data", data_out, 32'(k));
        end
        @(negedge clk);
        chk("os_drain_done", drain_done, 1);
        chk("os_valid_low", out_valid, 0);

        // Reset mid-drain after 10 elements
        os_capture(8, 8, 1'b0, 32'h0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("rd_data", data_out, 32'(k));
        end
        reset = 1'b0;
        #1;
        chk("rd_out_valid", out_valid, 0);
        chk("rd_data_zero", data_out, 0);
        chk("rd_busy", busy, 0);
        @(negedge clk);
        reset = 1'b1; buffer_mode = 2'b11;
        @(negedge clk);
        @(negedge clk);
        chk("rd_mode11_busy", busy, 0);
        chk("rd_mode11_valid", out_valid, 0);
        buffer_mode = 2'b00;

        // Backpressure N=1, M=4
        out_ready = 1'b0;
        os_capture(1, 4, 1'b0, 32'h100);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_data", data_out, 32'h100);
        end
        out_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            chk("bp_data", data_out, 32'h100 + 32'(k));
        end
        @(negedge clk);
        chk("bp_drain_done", drain_done, 1);
        chk("bp_valid_low", out_valid, 0);
        buffer_mode = 2'b00;

        // Rejected starts
        @(negedge clk);
        buffer_mode = 2'b01; N = 8'd9; M = 8'd2;
        @(negedge clk);
        chk("err_n9", cmd_err, 1);
        chk("err_n9_busy", busy, 0);
        N = 8'd3; M = 8'd0;
        @(negedge clk);
        chk("err_m0", cmd_err, 1);
        chk("err_m0_busy", busy, 0);
        buffer_mode = 2'b00;
        @(negedge clk);
        chk("err_clear", cmd_err, 0);

        // Start command while FULL is rejected and does not disturb data
        buffer_mode = 2'b10; N = 8'd1; M = 8'd2;
        @(negedge clk);
        in_valid = 1'b1; data_in = os_beat(32'h300, 0);
        @(negedge clk);
        chk("full_capture_done", capture_done, 1);
        in_valid = 1'b1; data_in = '1; buffer_mode = 2'b01;
        @(negedge clk);
        chk("full_cmd_err", cmd_err, 1);
        chk("full_busy", busy, 0);
        buffer_mode = 2'b00;
        @(negedge clk);
        chk("full_mode00_noerr", cmd_err, 0);
        chk("full_mode00_busy", busy, 0);
        buffer_mode = 2'b11; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("full_data0", data_out, 32'h300);
        @(negedge clk);
        chk("full_data1", data_out, 32'h301);
        @(negedge clk);
        chk("full_drain_done", drain_done, 1);
        buffer_mode = 2'b00;

        // Abort after two WS beats, then a fresh 1x1 capture
        @(negedge clk);
        buffer_mode = 2'b01; N = 8'd3; M = 8'd3;
        @(negedge clk);
        in_valid = 1'b1; data_in = os_beat(32'h777, 0);
        @(negedge clk);
        data_in = os_beat(32'h777, 1);
        @(negedge clk);
        buffer_mode = 2'b00; in_valid = 1'b0;
        @(negedge clk);
        chk("ab_busy", busy, 0);
        chk("ab_no_done", capture_done, 0);
        @(negedge clk);
        chk("ab_no_done2", capture_done, 0);
        os_capture(1, 1, 1'b0, 32'h5A5A_0000);
        @(negedge clk);
        chk("ab_fresh_valid", out_valid, 1);
        chk("ab_fresh_data", data_out, 32'h5A5A_0000);
        @(negedge clk);
        chk("ab_fresh_done", drain_done, 1);
        buffer_mode = 2'b00;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
